// File: rtl/arr_arb_pkg.sv
// Shared types and the round-robin selection helper for the array port arbiter.
package arr_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // One-hot pick of the first requester at or after ptr, wrapping at n.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] req,
        input logic [IDX_W-1:0]    ptr,
        input int                  n
    );
        logic [NREQ_MAX-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && (idx < NREQ_MAX) && req[idx[IDX_W-1:0]]) begin
                pick[idx[IDX_W-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arr_port_arbiter_rr_picker.sv
// Combinational round-robin select: first active request at or above ptr, wrapping.
module rr_picker
    import arr_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    logic [NREQ_MAX-1:0] req_ext;
    logic [NREQ_MAX-1:0] pick;
    logic [IDX_W-1:0]    ptr_ext;
    logic                unused_pick;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        ptr_ext             = '0;
        ptr_ext[PTR_W-1:0]  = ptr;
        pick                = rr_pick(req_ext, ptr_ext, NREQ);
    end

    assign gnt = pick[NREQ-1:0];
    // Upper pick bits are always zero because the request is zero-extended.
    assign unused_pick = ^pick;

endmodule

// File: rtl/arr_port_arbiter.sv
// Shares one single-port, 1-cycle-latency array RAM among NREQ requesters
// with lock sequences, host override and read-return routing.
//
// state  | meaning
// IDLE   | no lock owner; grant via host override or round-robin
// LOCKED | owner holds the port while it requests, up to MAX_LOCK grants
module arr_port_arbiter
    import arr_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 1,
    parameter int MAX_LOCK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_ovr,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     arrWEnable,
    output logic [ADDR_W-1:0]        arrAddr,
    output logic [DATA_W-1:0]        arrWData,
    input  logic [DATA_W-1:0]        arrRData
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [CNT_W-1:0]  lock_cnt;
    logic [NREQ-1:0]   rd_tag;

    logic [NREQ-1:0]   rr_gnt;
    logic [NREQ-1:0]   gnt_pre;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic [CNT_W-1:0]  cnt_new;
    logic              lock_hit;
    logic              host_hit;
    logic              rr_hit;
    logic              any_gnt;
    logic              gnt_lock;
    logic              force_rel;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req (req),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    always_comb begin
        lock_hit = (state == LOCKED) && req[owner] && (lock_cnt < CNT_W'(MAX_LOCK));
        host_hit = !lock_hit && host_ovr && req[0];
        rr_hit   = !lock_hit && !host_hit && (|req);
        gnt_pre  = '0;
        if (lock_hit) begin
            gnt_pre[owner] = 1'b1;
        end else if (host_hit) begin
            gnt_pre[0] = 1'b1;
        end else begin
            gnt_pre = rr_gnt;
        end
    end

    // Holding reset must never let a command through to the RAM.
    assign gnt = rst_n ? gnt_pre : '0;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        any_gnt   = |gnt;
        gnt_lock  = |(gnt & lock);
        cnt_new   = (lock_hit ? lock_cnt : '0) + CNT_W'(1);
        force_rel = gnt_lock && (cnt_new >= CNT_W'(MAX_LOCK));
        next_ptr  = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        arrWEnable = |(gnt & we);
        arrAddr    = '0;
        arrWData   = '0;
        if (any_gnt) begin
            arrAddr  = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            arrWData = wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        end
    end

    assign rvalid = rd_tag;
    assign rdata  = arrRData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            lock_cnt <= '0;
            rr_ptr   <= '0;
            rd_tag   <= '0;
        end else begin
            rd_tag <= gnt & ~we;
            // A forced release moves the pointer past the owner so others get a turn.
            if (rr_hit || force_rel) begin
                rr_ptr <= next_ptr;
            end
            if (gnt_lock && !force_rel) begin
                state    <= LOCKED;
                owner    <= gnt_idx;
                lock_cnt <= cnt_new;
            end else begin
                state    <= IDLE;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Directed bench for arr_port_arbiter: vector table plus lock-timeout and reset sequences.
module tb_arr_port_arbiter;

    localparam int NREQ     = 2;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 1;
    localparam int MAX_LOCK = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   host_ovr = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        lock = '0;
    logic [NREQ-1:0]        we = '0;
    logic [NREQ*ADDR_W-1:0] addr = '0;
    logic [NREQ*DATA_W-1:0] wdata = '0;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   arrWEnable;
    logic [ADDR_W-1:0]      arrAddr;
    logic [DATA_W-1:0]      arrWData;
    logic [DATA_W-1:0]      arr_rdata;
    logic [DATA_W-1:0]      mem [2];

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        h;
        logic [1:0]  rq;
        logic [1:0]  lk;
        logic [1:0]  w;
        logic        a0;
        logic        a1;
        logic [63:0] wd0;
        logic [63:0] wd1;
        logic [1:0]  g;
        logic [1:0]  rv;
        logic [63:0] rd;
    } vec_t;

    vec_t tv[$];
    logic [1:0] lt_req [6];
    logic       lt_h   [6];
    logic [1:0] lt_exp [6];

    always #5 clk = ~clk;

    arr_port_arbiter #(
        .NREQ     (NREQ),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_ovr   (host_ovr),
        .req        (req),
        .lock       (lock),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .arrWEnable (arrWEnable),
        .arrAddr    (arrAddr),
        .arrWData   (arrWData),
        .arrRData   (arr_rdata)
    );

    // RAM model with one-cycle read latency, preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0]    <= 64'd5;
            mem[1]    <= 64'hAAAA;
            arr_rdata <= '0;
        end else begin
            if (arrWEnable) begin
                mem[arrAddr] <= arrWData;
            end
            arr_rdata <= mem[arrAddr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic h, input logic [1:0] rq, input logic [1:0] lk,
                       input logic [1:0] w, input logic a0, input logic a1,
                       input logic [63:0] wd0, input logic [63:0] wd1,
                       input logic [1:0] g, input logic [1:0] rv, input logic [63:0] rd);
        vec_t v;
        v.h = h;  v.rq = rq; v.lk = lk; v.w = w; v.a0 = a0; v.a1 = a1;
        v.wd0 = wd0; v.wd1 = wd1; v.g = g; v.rv = rv; v.rd = rd;
        tv.push_back(v);
    endtask

    task automatic drive(input logic h, input logic [1:0] rq, input logic [1:0] lk,
                         input logic [1:0] w, input logic a0, input logic a1,
                         input logic [63:0] wd0, input logic [63:0] wd1);
        host_ovr = h;
        req      = rq;
        lock     = lk;
        we       = w;
        addr     = {a1, a0};
        wdata    = {wd1, wd0};
    endtask

    initial begin
        //   h  req    lock   we     a0 a1 wd0       wd1    | gnt    rvalid rdata
        add(0, 2'b11, 2'b00, 2'b00, 0, 1, 0,        0,       2'b01, 2'b00, 0);
        add(0, 2'b11, 2'b00, 2'b00, 0, 1, 0,        0,       2'b10, 2'b01, 64'd5);
        add(0, 2'b11, 2'b00, 2'b00, 0, 1, 0,        0,       2'b01, 2'b10, 64'hAAAA);
        add(1, 2'b11, 2'b00, 2'b00, 0, 1, 0,        0,       2'b01, 2'b01, 64'd5);
        add(1, 2'b11, 2'b00, 2'b00, 0, 1, 0,        0,       2'b01, 2'b01, 64'd5);
        add(0, 2'b11, 2'b00, 2'b00, 0, 1, 0,        0,       2'b10, 2'b01, 64'd5);
        add(0, 2'b01, 2'b00, 2'b00, 0, 1, 0,        0,       2'b01, 2'b10, 64'hAAAA);
        add(0, 2'b11, 2'b10, 2'b00, 0, 0, 0,        0,       2'b10, 2'b01, 64'd5);
        add(1, 2'b11, 2'b00, 2'b10, 0, 0, 0,        64'd6,   2'b10, 2'b10, 64'd5);
        add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0,        0,       2'b01, 2'b00, 0);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 0,        0,       2'b00, 2'b01, 64'd6);
        add(0, 2'b01, 2'b00, 2'b01, 1, 0, 64'h1234, 0,       2'b01, 2'b00, 0);
        add(0, 2'b10, 2'b00, 2'b00, 1, 1, 0,        0,       2'b10, 2'b00, 0);
        add(0, 2'b00, 2'b00, 2'b00, 1, 1, 0,        0,       2'b00, 2'b10, 64'h1234);

        lt_req = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        lt_h   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        lt_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

        // Power-on reset with requests (including writes) pending.
        rst_n = 1'b0;
        req   = 2'b11;
        we    = 2'b11;
        #2;
        chk("reset gnt", 64'(gnt), 64'(2'b00));
        chk("reset rvalid", 64'(rvalid), 64'(2'b00));
        chk("reset arrWEnable", 64'(arrWEnable), 64'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = '0;
        we    = '0;
        @(negedge clk);
        chk("idle gnt", 64'(gnt), 64'(2'b00));
        chk("idle rvalid", 64'(rvalid), 64'(2'b00));

        foreach (tv[i]) begin
            @(posedge clk);
            #1;
            drive(tv[i].h, tv[i].rq, tv[i].lk, tv[i].w, tv[i].a0, tv[i].a1, tv[i].wd0, tv[i].wd1);
            @(negedge clk);
            chk($sformatf("row%0d gnt", i), 64'(gnt), 64'(tv[i].g));
            chk($sformatf("row%0d rvalid", i), 64'(rvalid), 64'(tv[i].rv));
            if (tv[i].rv != 2'b00) begin
                chk($sformatf("row%0d rdata", i), rdata, tv[i].rd);
            end
        end

        // Lock held past MAX_LOCK grants, host_ovr asserted while locked.
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            drive(lt_h[c], lt_req[c], 2'b10, 2'b00, 0, 1, 0, 0);
            @(negedge clk);
            chk($sformatf("locktimeout c%0d gnt", c), 64'(gnt), 64'(lt_exp[c]));
        end
        @(posedge clk);
        #1;
        drive(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("lock drop gnt", 64'(gnt), 64'(2'b00));

        // Reset mid-read while requester 0 holds a lock and rr_ptr is 1.
        @(posedge clk);
        #1;
        drive(0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        chk("prereset gnt", 64'(gnt), 64'(2'b01));
        @(posedge clk);
        #1;
        chk("prereset rvalid", 64'(rvalid), 64'(2'b01));
        rst_n = 1'b0;
        drive(0, 2'b11, 2'b00, 2'b11, 0, 1, 64'h77, 64'h88);
        #1;
        chk("midreset gnt", 64'(gnt), 64'(2'b00));
        chk("midreset rvalid", 64'(rvalid), 64'(2'b00));
        chk("midreset arrWEnable", 64'(arrWEnable), 64'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        we    = 2'b00;
        @(negedge clk);
        chk("postreset gnt", 64'(gnt), 64'(2'b01));
        chk("postreset rvalid", 64'(rvalid), 64'(2'b00));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
